branch_resolve_unit: RTL and testbench

//   ID-stage branch/jump resolver. Handles all RV32I B-type conditions plus JAL/JALR, with operand forwarding.

---
 rtl/branch_resolve_unit_pkg.sv | 32 +++
 rtl/branch_resolve_unit_if.sv | 42 ++++
 rtl/branch_resolve_unit_branch_history_table.sv | 29 ++
 rtl/branch_resolve_unit.sv | 100 ++++++++++
 tb/tb_branch_resolve_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the ID-stage branch resolver: opcodes, funct3 conditions,
// forward-select codes and the BHT counter reset value.
package branch_resolve_unit_pkg;

    typedef enum logic [6:0] {
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        FWD_REG     = 2'd0,
        FWD_ALU     = 2'd1,
        FWD_ALU_MEM = 2'd2,
        FWD_REG_ALT = 2'd3
    } fwd_sel_e;

    localparam logic [1:0] BHT_WEAK_NT = 2'b01;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// ID-stage branch interface: IF lookup, decoded instruction with forwarding
// sources, and the registered redirect/statistics outputs.
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  if_pc;
    logic             if_pred_taken;
    logic             id_valid;
    logic             stall;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_pred_npc;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  immValue;
    logic [XLEN-1:0]  source1;
    logic [XLEN-1:0]  source2;
    logic [1:0]       select1;
    logic [1:0]       select2;
    logic [XLEN-1:0]  wbALU;
    logic [XLEN-1:0]  wbALUMem;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_addr;
    logic [XLEN-1:0]  link_data;
    logic             misalign;
    logic [CNT_W-1:0] cnt_branch;
    logic [CNT_W-1:0] cnt_mispredict;

    modport master (
        output if_pc, id_valid, stall, id_pc, id_pred_npc, opcode, funct3, immValue,
               source1, source2, select1, select2, wbALU, wbALUMem,
        input  if_pred_taken, redirect_valid, redirect_addr, link_data, misalign,
               cnt_branch, cnt_mispredict
    );

    modport slave (
        input  if_pc, id_valid, stall, id_pc, id_pred_npc, opcode, funct3, immValue,
               source1, source2, select1, select2, wbALU, wbALUMem,
        output if_pred_taken, redirect_valid, redirect_addr, link_data, misalign,
               cnt_branch, cnt_mispredict
    );
endinterface

// File: rtl/branch_resolve_unit_branch_history_table.sv
// Array of 2-bit saturating counters: one combinational read port for IF,
// one write port updated on the resolve edge.
module branch_history_table
    import branch_resolve_unit_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);
    logic [1:0] ctr [ENTRIES];

    // Read is from the array state, so a same-cycle write shows up only after the edge.
    assign rd_ctr = ctr[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= BHT_WEAK_NT;
        end else if (wr_en) begin
            ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken);
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch/jump resolver: forwards operands, evaluates the condition,
// checks the fetched next PC and issues a registered redirect on mismatch.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input logic clk,
    input logic rst,
    branch_resolve_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    function automatic logic [XLEN-1:0] fwd(input logic [1:0] sel, input logic [XLEN-1:0] reg_v,
                                            input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem);
        case (sel)
            FWD_ALU:     return alu;
            FWD_ALU_MEM: return mem;
            default:     return reg_v;
        endcase
    endfunction

    logic [XLEN-1:0] rs1, rs2, pc_plus4, br_tgt, jalr_tgt, tgt, actual_npc;
    logic            is_br, is_jal, is_jalr, resolve, legal, cond, taken, mis, mispredict;
    logic            bht_we;
    logic [1:0]      bht_rd;

    always_comb begin
        rs1      = fwd(bus.select1, bus.source1, bus.wbALU, bus.wbALUMem);
        rs2      = fwd(bus.select2, bus.source2, bus.wbALU, bus.wbALUMem);
        is_br    = (bus.opcode == OP_BRANCH);
        is_jal   = (bus.opcode == OP_JAL);
        is_jalr  = (bus.opcode == OP_JALR);
        resolve  = bus.id_valid && !bus.stall && (is_br || is_jal || is_jalr);

        legal = 1'b1;
        cond  = 1'b0;
        case (bus.funct3)
            F3_BEQ:  cond = (rs1 == rs2);
            F3_BNE:  cond = (rs1 != rs2);
            F3_BLT:  cond = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  cond = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: cond = (rs1 <  rs2);
            F3_BGEU: cond = (rs1 >= rs2);
            default: legal = 1'b0;
        endcase

        pc_plus4   = bus.id_pc + XLEN'(4);
        br_tgt     = bus.id_pc + bus.immValue;
        jalr_tgt   = (rs1 + bus.immValue) & ~XLEN'(1);
        tgt        = is_jalr ? jalr_tgt : br_tgt;
        taken      = is_jal || is_jalr || (is_br && legal && cond);
        actual_npc = taken ? tgt : pc_plus4;
        mis        = taken && (tgt[1:0] != 2'b00);
        // A misaligned target traps instead of redirecting, so it never trains the BHT.
        mispredict = resolve && !mis && (actual_npc != bus.id_pred_npc);
        bht_we     = resolve && is_br && legal && !mis;
    end

    branch_history_table #(.ENTRIES(BHT_ENTRIES), .IDX_W(IDX_W)) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (bus.if_pc[IDX_W+1:2]),
        .rd_ctr   (bht_rd),
        .wr_en    (bht_we),
        .wr_idx   (bus.id_pc[IDX_W+1:2]),
        .wr_taken (taken)
    );

    assign bus.if_pred_taken = bht_rd[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.redirect_valid <= 1'b0;
            bus.redirect_addr  <= '0;
            bus.link_data      <= '0;
            bus.misalign       <= 1'b0;
        end else begin
            bus.redirect_valid <= mispredict;
            bus.misalign       <= resolve && mis;
            if (mispredict) bus.redirect_addr <= actual_npc;
            // Link value is the rd result of every resolved jump, predicted correctly or not.
            if (resolve && (is_jal || is_jalr)) bus.link_data <= pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cnt_branch     <= '0;
            bus.cnt_mispredict <= '0;
        end else begin
            if (resolve && is_br && (bus.cnt_branch != '1))
                bus.cnt_branch <= bus.cnt_branch + CNT_W'(1);
            if (mispredict && (bus.cnt_mispredict != '1))
                bus.cnt_mispredict <= bus.cnt_mispredict + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit against a behavioural model
// (BHT as an int array, counters as saturating ints, expected outputs per edge).
module tb_branch_resolve_unit;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam logic [6:0] OPB = 7'b1100011, OPJ = 7'b1101111, OPJR = 7'b1100111, OPX = 7'b0010011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(16), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int m_bht [16];
    int m_cb, m_cm;
    logic e_rv, e_mis;
    logic [31:0] e_ra, e_ld;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_cb = 0; m_cm = 0;
        e_rv = 0; e_mis = 0; e_ra = 0; e_ld = 0;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r);
        if (sel == 2'd1) return bus.wbALU;
        if (sel == 2'd2) return bus.wbALUMem;
        return r;
    endfunction

    // Applies the rules of one resolve edge to the model, using the inputs held before it.
    task automatic model_edge();
        logic [31:0] r1, r2, tgt, npc;
        logic isb, isj, isjr, legal, cond, tk, mis;
        int idx;
        e_rv = 0; e_mis = 0;
        isb = (bus.opcode == OPB); isj = (bus.opcode == OPJ); isjr = (bus.opcode == OPJR);
        if (!bus.id_valid || bus.stall || !(isb || isj || isjr)) return;
        r1 = pick(bus.select1, bus.source1);
        r2 = pick(bus.select2, bus.source2);
        legal = 1; cond = 0;
        case (bus.funct3)
            3'd0: cond = r1 == r2;
            3'd1: cond = r1 != r2;
            3'd4: cond = $signed(r1) < $signed(r2);
            3'd5: cond = $signed(r1) >= $signed(r2);
            3'd6: cond = r1 < r2;
            3'd7: cond = r1 >= r2;
            default: legal = 0;
        endcase
        tk  = isj || isjr || (isb && legal && cond);
        tgt = isjr ? ((r1 + bus.immValue) & 32'hFFFF_FFFE) : (bus.id_pc + bus.immValue);
        npc = tk ? tgt : bus.id_pc + 32'd4;
        mis = tk && (tgt % 4 != 0);
        if (isb && m_cb < CMAX) m_cb++;
        if (isj || isjr) e_ld = bus.id_pc + 32'd4;
        if (mis) e_mis = 1;
        else if (npc != bus.id_pred_npc) begin
            e_rv = 1; e_ra = npc;
            if (m_cm < CMAX) m_cm++;
        end
        if (isb && legal && !mis) begin
            idx = (bus.id_pc >> 2) % 16;
            m_bht[idx] = tk ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                            : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] pred, input logic [31:0] imm,
                          input logic [31:0] s1, input logic [31:0] s2);
        bus.id_valid = 1; bus.stall = 0; bus.opcode = op; bus.funct3 = f3;
        bus.id_pc = pc; bus.id_pred_npc = pred; bus.immValue = imm;
        bus.source1 = s1; bus.source2 = s2; bus.select1 = 0; bus.select2 = 0;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.stall = 0; bus.opcode = OPX;
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'd5;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Single compare process: every registered output and the IF prediction, every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("redirect_valid", 32'(bus.redirect_valid), 32'(e_rv));
            chk("redirect_addr", bus.redirect_addr, e_ra);
            chk("link_data", bus.link_data, e_ld);
            chk("misalign", 32'(bus.misalign), 32'(e_mis));
            chk("cnt_branch", 32'(bus.cnt_branch), 32'(m_cb));
            chk("cnt_mispredict", 32'(bus.cnt_mispredict), 32'(m_cm));
            chk("if_pred_taken", 32'(bus.if_pred_taken), 32'(m_bht[(bus.if_pc >> 2) % 16] >= 2));
        end
    end

    initial begin
        int imm, r;
        bus.if_pc = 0; bus.id_pc = 0; bus.id_pred_npc = 0; bus.funct3 = 0; bus.immValue = 0;
        bus.source1 = 0; bus.source2 = 0; bus.select1 = 0; bus.select2 = 0;
        bus.wbALU = 0; bus.wbALUMem = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk("reset redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("reset cnt_branch", 32'(bus.cnt_branch), 32'd0);
        @(negedge clk); #1 rst = 0;

        // BEQ taken, mispredicted; BHT[0] 01 -> 10
        chk("bht0 initial", 32'(bus.if_pred_taken), 32'd0);
        set_in(OPB, 3'd0, 32'h100, 32'h104, 32'd16, 32'd5, 32'd5);
        step(); idle();
        chk("beq redirect", 32'(bus.redirect_valid), 32'd1);
        chk("beq addr", bus.redirect_addr, 32'h110);
        #1 chk("bht0 after beq", 32'(bus.if_pred_taken), 32'd1);

        set_in(OPB, 3'd4, 32'h200, 32'h204, 32'd8, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("blt taken addr", bus.redirect_addr, 32'h208);
        set_in(OPB, 3'd6, 32'h200, 32'h204, 32'd8, 32'hFFFF_FFFF, 32'd1);
        step(); idle();
        chk("bltu no redirect", 32'(bus.redirect_valid), 32'd0);

        set_in(OPB, 3'd0, 32'h300, 32'h304, 32'h10, 32'd0, 32'd7);
        bus.select1 = 1; bus.wbALU = 7;
        step();
        chk("fwd alu taken", bus.redirect_addr, 32'h310);
        set_in(OPB, 3'd0, 32'h300, 32'h310, 32'h10, 32'd0, 32'd7);
        bus.select1 = 2; bus.wbALUMem = 8;
        step(); idle();
        chk("fwd mem not-taken", bus.redirect_addr, 32'h304);

        set_in(OPJR, 3'd0, 32'h400, 32'h404, 32'd0, 32'h203, 32'd0);
        step();
        chk("jalr 0x202 misalign", 32'(bus.misalign), 32'd1);
        chk("jalr link", bus.link_data, 32'h404);
        set_in(OPJR, 3'd0, 32'h400, 32'h404, 32'd1, 32'h203, 32'd0);
        step();
        chk("jalr clear bit0", bus.redirect_addr, 32'h204);
        set_in(OPJ, 3'd0, 32'h500, 32'h504, 32'd2, 32'd0, 32'd0);
        step(); idle();
        chk("jal misalign", 32'(bus.misalign), 32'd1);
        chk("jal no redirect", 32'(bus.redirect_valid), 32'd0);

        for (int i = 0; i < 4; i++) begin
            set_in(OPB, 3'd0, 32'h40, 32'h48, 32'd8, 32'd3, 32'd3);
            step();
        end
        idle();
        bus.if_pc = 32'h40;
        #1 chk("bht sat pred", 32'(bus.if_pred_taken), 32'd1);

        set_in(OPB, 3'd0, 32'h44, 32'h48, 32'h20, 32'd1, 32'd1);
        bus.stall = 1; bus.if_pc = 32'h44;
        step(); idle();
        chk("stall no pulse", 32'(bus.redirect_valid), 32'd0);
        chk("stall cnt_branch", 32'(bus.cnt_branch), 32'd9);
        chk("stall cnt_mispredict", 32'(bus.cnt_mispredict), 32'd5);
        #1 chk("stall bht frozen", 32'(bus.if_pred_taken), 32'd0);

        // Random phase; the narrow counters saturate along the way
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 5);
            bus.opcode = (r <= 2) ? OPB : (r == 3) ? OPJ : (r == 4) ? OPJR : OPX;
            bus.funct3 = 3'($urandom_range(0, 7));
            bus.id_valid = ($urandom_range(0, 9) != 0);
            bus.stall = ($urandom_range(0, 9) == 0);
            bus.id_pc = 32'($urandom_range(0, 63)) << 2;
            imm = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) - 4 : ($urandom_range(0, 63) - 32) * 4;
            bus.immValue = 32'(imm);
            r = $urandom_range(0, 2);
            bus.id_pred_npc = (r == 0) ? bus.id_pc + 4 : (r == 1) ? bus.id_pc + bus.immValue
                                                                 : 32'($urandom_range(0, 255)) << 2;
            bus.source1 = rand_op(); bus.source2 = rand_op();
            bus.wbALU = rand_op(); bus.wbALUMem = rand_op();
            bus.select1 = 2'($urandom_range(0, 3)); bus.select2 = 2'($urandom_range(0, 3));
            bus.if_pc = ($urandom_range(0, 1) != 0) ? bus.id_pc : 32'($urandom_range(0, 63)) << 2;
            step();
        end
        idle();
        step();
        chk("cnt_branch saturated", 32'(bus.cnt_branch), 32'(CMAX));

        // Async reset in the middle of a redirect pulse
        set_in(OPB, 3'd1, 32'h80, 32'h84, 32'h10, 32'd1, 32'd2);
        step(); idle();
        chk("pre-reset pulse", 32'(bus.redirect_valid), 32'd1);
        #1 rst = 1;
        model_reset();
        #1 chk("rst drops pulse", 32'(bus.redirect_valid), 32'd0);
        chk("rst cnt_branch", 32'(bus.cnt_branch), 32'd0);
        chk("rst cnt_mispredict", 32'(bus.cnt_mispredict), 32'd0);
        for (int i = 0; i < 16; i++) begin
            bus.if_pc = 32'(i) << 2;
            #0.1 chk("rst bht entry", 32'(bus.if_pred_taken), 32'd0);
        end
        @(negedge clk); #1 rst = 0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
